// File: rtl/gf_pkg.sv
// Shared GF(2^m) evaluator types and constants.
// Optional zero_mask output is enabled by defining GF_EVAL_ZERO_FLAG_EN.
package gf_pkg;

  localparam int unsigned DEF_SYM_W     = 8;
  localparam logic [8:0]  DEF_PRIM_POLY = 9'h11D;
  localparam int unsigned MAX_SYM_W     = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  // Low sym_w bits of the primitive polynomial: the value folded back in when x^m overflows.
  function automatic logic [MAX_SYM_W-1:0] red_mask(input logic [MAX_SYM_W:0] poly,
                                                    input int unsigned      sym_w);
    logic [MAX_SYM_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_SYM_W; i++) begin
      m[i] = (i < sym_w) ? poly[i] : 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/gf_multipoint_evaluator_if.sv
// Control, coefficient-stream and result-handshake bundle of the multipoint evaluator.
// zero_mask is present only when GF_EVAL_ZERO_FLAG_EN is defined.
interface gf_multipoint_evaluator_if #(
  parameter int unsigned SYM_W   = 8,
  parameter int unsigned NUM_PTS = 4,
  parameter int unsigned DEG_W   = 8
);
  logic                     start;
  logic [DEG_W-1:0]         degree;
  logic [NUM_PTS*SYM_W-1:0] points;
  logic [SYM_W-1:0]         coeff;
  logic                     coeff_valid;
  logic                     coeff_ready;
  logic                     busy;
  logic [NUM_PTS*SYM_W-1:0] result;
  logic                     result_valid;
  logic                     result_ready;
`ifdef GF_EVAL_ZERO_FLAG_EN
  logic [NUM_PTS-1:0]       zero_mask;
`endif

  modport master (
`ifdef GF_EVAL_ZERO_FLAG_EN
    input  zero_mask,
`endif
    output start, degree, points, coeff, coeff_valid, result_ready,
    input  coeff_ready, busy, result, result_valid
  );

  modport slave (
`ifdef GF_EVAL_ZERO_FLAG_EN
    output zero_mask,
`endif
    input  start, degree, points, coeff, coeff_valid, result_ready,
    output coeff_ready, busy, result, result_valid
  );

endinterface

// File: rtl/gf_mul.sv
// Combinational GF(2^SYM_W) multiplier: shift-and-add with per-step reduction.
module gf_mul
  import gf_pkg::*;
#(
  parameter int unsigned      SYM_W     = DEF_SYM_W,
  parameter logic [SYM_W:0]   PRIM_POLY = (SYM_W+1)'(DEF_PRIM_POLY)
) (
  input  logic [SYM_W-1:0] a,
  input  logic [SYM_W-1:0] b,
  output logic [SYM_W-1:0] y
);

  localparam logic [SYM_W-1:0] RMASK = SYM_W'(red_mask((MAX_SYM_W+1)'(PRIM_POLY), SYM_W));

  logic [SYM_W-1:0] sum;
  logic [SYM_W-1:0] sh;

  always_comb begin
    sum = '0;
    sh  = a;
    for (int unsigned i = 0; i < SYM_W; i++) begin
      if (b[i]) sum = sum ^ sh;
      sh = sh[SYM_W-1] ? ((sh << 1) ^ RMASK) : (sh << 1);
    end
    y = sum;
  end

endmodule

// File: rtl/gf_multipoint_evaluator.sv
// Horner evaluation of one streamed polynomial at NUM_PTS points in parallel.
// Define GF_EVAL_ZERO_FLAG_EN to add the registered per-point zero_mask output.
module gf_multipoint_evaluator
  import gf_pkg::*;
#(
  parameter int unsigned    SYM_W     = DEF_SYM_W,
  parameter logic [SYM_W:0] PRIM_POLY = (SYM_W+1)'(DEF_PRIM_POLY),
  parameter int unsigned    MAX_DEG   = 255,
  parameter int unsigned    NUM_PTS   = 4,
  localparam int unsigned   DEG_W     = $clog2(MAX_DEG + 1)
) (
  input logic                      clk,
  input logic                      rst_n,
  gf_multipoint_evaluator_if.slave bus
);

  state_e                   state_q;
  logic [DEG_W-1:0]         cnt_q;
  logic [DEG_W-1:0]         deg_sat;
  logic [SYM_W-1:0]         pts_q [NUM_PTS];
  logic [SYM_W-1:0]         acc_q [NUM_PTS];
  logic [SYM_W-1:0]         acc_d [NUM_PTS];
  logic [NUM_PTS*SYM_W-1:0] acc_d_flat;
  logic [NUM_PTS*SYM_W-1:0] result_q;
`ifdef GF_EVAL_ZERO_FLAG_EN
  logic [NUM_PTS-1:0]       zero_d;
  logic [NUM_PTS-1:0]       zero_q;
`endif

  assign deg_sat = (32'(bus.degree) > MAX_DEG) ? DEG_W'(MAX_DEG) : bus.degree;

  for (genvar p = 0; p < NUM_PTS; p++) begin : g_pt
    logic [SYM_W-1:0] prod;

    gf_mul #(
      .SYM_W     (SYM_W),
      .PRIM_POLY (PRIM_POLY)
    ) u_mul (
      .a (acc_q[p]),
      .b (pts_q[p]),
      .y (prod)
    );

    assign acc_d[p]                     = prod ^ bus.coeff;
    assign acc_d_flat[p*SYM_W +: SYM_W] = acc_d[p];
`ifdef GF_EVAL_ZERO_FLAG_EN
    assign zero_d[p]                    = (acc_d[p] == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
      for (int p = 0; p < NUM_PTS; p++) begin
        acc_q[p] <= '0;
        pts_q[p] <= '0;
      end
`ifdef GF_EVAL_ZERO_FLAG_EN
      zero_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StAccum;
            cnt_q   <= deg_sat;
            for (int p = 0; p < NUM_PTS; p++) begin
              acc_q[p] <= '0;
              pts_q[p] <= bus.points[p*SYM_W +: SYM_W];
            end
          end
        end
        StAccum: begin
          // coeff_ready is high throughout this state, so valid alone is the handshake.
          if (bus.coeff_valid) begin
            for (int p = 0; p < NUM_PTS; p++) acc_q[p] <= acc_d[p];
            if (cnt_q == '0) begin
              state_q  <= StHold;
              result_q <= acc_d_flat;
`ifdef GF_EVAL_ZERO_FLAG_EN
              zero_q   <= zero_d;
`endif
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        StHold: begin
          if (bus.result_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.coeff_ready  = (state_q == StAccum);
  assign bus.busy         = (state_q != StIdle);
  assign bus.result_valid = (state_q == StHold);
  assign bus.result       = result_q;
`ifdef GF_EVAL_ZERO_FLAG_EN
  assign bus.zero_mask    = zero_q;
`endif

endmodule

// File: tb/tb_gf_multipoint_evaluator.sv
// Directed and table-driven bench for gf_multipoint_evaluator (SYM_W=8, poly 0x11D, 4 points).
module tb_gf_multipoint_evaluator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  coef_mem [256];
  logic [31:0] last_res;
  logic [3:0]  last_zm;

  gf_multipoint_evaluator_if #(.SYM_W(8), .NUM_PTS(4), .DEG_W(8)) bus ();

  gf_multipoint_evaluator #(
    .SYM_W     (8),
    .PRIM_POLY (9'h11D),
    .MAX_DEG   (255),
    .NUM_PTS   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          deg;
    logic [31:0] pts;
    logic [7:0]  c [4];
    int          gap;
    logic [31:0] exp_res;
    logic [3:0]  exp_zm;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full carry-less product, then reduction from the top bit down.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011D << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] model(input int deg, input logic [31:0] pts);
    logic [31:0] r;
    logic [7:0]  acc;
    logic [7:0]  x;
    r = '0;
    for (int p = 0; p < 4; p++) begin
      x   = pts[p*8 +: 8];
      acc = '0;
      for (int i = 0; i <= deg; i++) acc = gmul(acc, x) ^ coef_mem[i];
      r[p*8 +: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [3:0] zmask(input logic [31:0] r);
    logic [3:0] z;
    for (int p = 0; p < 4; p++) z[p] = (r[p*8 +: 8] == 8'h00);
    return z;
  endfunction

  // Entered and left at a negedge. With keep_start, start stays high carrying the next job's
  // degree/points so any illegal restart would corrupt this job.
  task automatic run_job(input int deg, input logic [31:0] pts, input int gap, input int hold,
                         input bit pre_started, input bit keep_start,
                         input logic [7:0] nxt_deg, input logic [31:0] nxt_pts);
    int          idx;
    int          budget;
    logic [31:0] held;
    idx    = 0;
    budget = 4 * (deg + 1) + 20;
    if (!pre_started) begin
      bus.start  = 1'b1;
      bus.degree = 8'(deg);
      bus.points = pts;
      @(negedge clk);
    end
    if (keep_start) begin
      bus.start  = 1'b1;
      bus.degree = nxt_deg;
      bus.points = nxt_pts;
    end else begin
      bus.start = 1'b0;
    end
    check("busy_in_accum", 32'(bus.busy), 32'd1);
    while (idx <= deg && budget > 0) begin
      if (int'($urandom_range(99)) < gap) begin
        bus.coeff_valid = 1'b0;
      end else begin
        bus.coeff_valid = 1'b1;
        bus.coeff       = coef_mem[idx];
        if (bus.coeff_ready) idx++;
      end
      @(negedge clk);
      budget--;
    end
    bus.coeff_valid = 1'b0;
    if (idx <= deg) check("coeff_accept_timeout", 32'(idx), 32'(deg + 1));
    check("result_valid_latency", 32'(bus.result_valid), 32'd1);
    held    = bus.result;
`ifdef GF_EVAL_ZERO_FLAG_EN
    last_zm = bus.zero_mask;
`endif
    for (int h = 0; h < hold; h++) begin
      bus.coeff_valid = 1'b1;
      bus.coeff       = 8'h5A;
      @(negedge clk);
      check("coeff_ready_in_hold", 32'(bus.coeff_ready), 32'd0);
      check("result_stable_in_hold", bus.result, held);
    end
    bus.coeff_valid  = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd0);
    check("result_valid_after_accept", 32'(bus.result_valid), 32'd0);
    last_res = held;
  endtask

  initial begin
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] pts2;

    bus.start        = 1'b0;
    bus.degree       = '0;
    bus.points       = '0;
    bus.coeff        = '0;
    bus.coeff_valid  = 1'b0;
    bus.result_ready = 1'b0;
    last_zm          = '0;

    vecs[0] = '{deg: 2, pts: 32'h00040201, c: '{8'h01, 8'h03, 8'h02, 8'h00}, gap: 0,
                exp_res: 32'h021E0000, exp_zm: 4'b0011};
    vecs[1] = '{deg: 2, pts: 32'h02000180, c: '{8'h01, 8'h00, 8'h00, 8'h00}, gap: 0,
                exp_res: 32'h04000113, exp_zm: 4'b0100};
    vecs[2] = '{deg: 0, pts: 32'h01FF8000, c: '{8'hA5, 8'h00, 8'h00, 8'h00}, gap: 0,
                exp_res: 32'hA5A5A5A5, exp_zm: 4'b0000};
    vecs[3] = '{deg: 1, pts: 32'h00FF0302, c: '{8'h03, 8'h05, 8'h00, 8'h00}, gap: 40,
                exp_res: 32'h05190003, exp_zm: 4'b0010};

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_result_valid", 32'(bus.result_valid), 32'd0);
    check("reset_result", bus.result, 32'h0);
    check("reset_coeff_ready", 32'(bus.coeff_ready), 32'd0);
`ifdef GF_EVAL_ZERO_FLAG_EN
    check("reset_zero_mask", 32'(bus.zero_mask), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) coef_mem[i] = vecs[v].c[i];
      run_job(vecs[v].deg, vecs[v].pts, vecs[v].gap, 1, 1'b0, 1'b0, 8'h00, 32'h0);
      check($sformatf("vec%0d_result", v), last_res, vecs[v].exp_res);
`ifdef GF_EVAL_ZERO_FLAG_EN
      check($sformatf("vec%0d_zero_mask", v), 32'(last_zm), 32'(vecs[v].exp_zm));
`endif
    end

    // Reset mid-ACCUM: job abandoned, result register cleared, idle offers ignored.
    bus.start  = 1'b1;
    bus.degree = 8'd5;
    bus.points = 32'h11223344;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.coeff_valid = 1'b1;
    bus.coeff       = 8'h77;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_result", bus.result, 32'h0);
    check("midreset_result_valid", 32'(bus.result_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_coeff_ready", 32'(bus.coeff_ready), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
    end
    bus.coeff_valid = 1'b0;

    // Stalls and 10-cycle backpressure.
    for (int i = 0; i < 6; i++) coef_mem[i] = 8'($urandom);
    pts2 = $urandom;
    exp1 = model(5, pts2);
    run_job(5, pts2, 50, 10, 1'b0, 1'b0, 8'h00, 32'h0);
    check("stall_result", last_res, exp1);
`ifdef GF_EVAL_ZERO_FLAG_EN
    check("stall_zero_mask", 32'(last_zm), 32'(zmask(exp1)));
`endif

    // Full-length back-to-back jobs with start held through ACCUM, HOLD and the release cycle.
    for (int i = 0; i < 256; i++) coef_mem[i] = 8'($urandom);
    exp1 = model(255, 32'h8E03C701);
    pts2 = 32'h00A51D02;
    run_job(255, 32'h8E03C701, 0, 2, 1'b0, 1'b1, 8'd255, pts2);
    check("full1_result", last_res, exp1);
    @(negedge clk);
    check("start_taken_after_hold", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 256; i++) coef_mem[i] = 8'($urandom);
    exp2 = model(255, pts2);
    run_job(255, pts2, 10, 0, 1'b1, 1'b0, 8'h00, 32'h0);
    check("full2_result", last_res, exp2);
`ifdef GF_EVAL_ZERO_FLAG_EN
    check("full2_zero_mask", 32'(last_zm), 32'(zmask(exp2)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gf_multipoint_evaluator.md
Name: gf_multipoint_evaluator

Overview:
Parametrised successor to the single-point Horner evaluator. It evaluates one streamed polynomial over GF(2^SYM_W) at NUM_PTS points in parallel, so one coefficient pass yields all results.
- Intended users: syndrome computation and Chien-style root search in the Reed-Solomon decoder.
- Handshakes: valid/ready on the coefficient input and on the result output, plus explicit start/busy.

Parameters:
SYM_W, 8, symbol width m of GF(2^m).
PRIM_POLY, 9'h11D, field primitive polynomial, SYM_W+1 bits, MSB set.
MAX_DEG, 255, largest supported polynomial degree.
NUM_PTS, 4, number of evaluation points processed in parallel.
DEG_W (localparam), $clog2(MAX_DEG+1), width of degree/counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin evaluation; sampled only in IDLE.
degree  in  DEG_W  polynomial degree d; latched on start.
points  in  NUM_PTS*SYM_W  evaluation points; point p is in bits [p*SYM_W +: SYM_W]; latched on start.
coeff  in  SYM_W  coefficient, highest order first.
coeff_valid  in  1  coeff is valid.
coeff_ready  out  1  block accepts coeff.
busy  out  1  high in any state other than IDLE.
result  out  NUM_PTS*SYM_W  p(x_p), packed like points.
result_valid  out  1  result is valid.
result_ready  in  1  consumer accepts result.

Behaviour:
- Reset (async assert, sync release): state=IDLE. Outputs: coeff_ready=0, busy=0, result_valid=0, result=0. Accumulators and counter cleared. Reset mid-operation abandons the job with no output.
- FSM states are IDLE, ACCUM and HOLD.
- IDLE:
  - start=1 latches points and degree, clears acc[0..NUM_PTS-1], sets cnt=degree, goes to ACCUM.
  - Coefficients offered in IDLE are not accepted (coeff_ready=0).
- ACCUM:
  - coeff_ready=1, combinational from state only.
  - On each coeff_valid&&coeff_ready, for every p: acc[p] <= gf_mul(acc[p], x_p) ^ coeff.
  - Exactly degree+1 coefficients are consumed.
  - If cnt==0 at the handshake: go to HOLD and register result from the updated accumulators. Otherwise cnt <= cnt-1.
  - Stalls (coeff_valid=0) hold all state.
- HOLD: result_valid=1, coeff_ready=0. On result_ready=1, go to IDLE and clear result_valid. result stays stable until accepted.
- Latency and throughput:
  - result_valid rises the cycle after the last coefficient handshake.
  - Throughput is 1 coefficient/cycle; a degree-d job takes at least d+3 cycles from start to return to IDLE.
- Boundaries:
  - degree=0 gives result=coeff for all p.
  - x_p=0 gives the constant term.
  - degree>MAX_DEG is saturated to MAX_DEG.
  - start while busy is ignored (no restart).
  - start in the same cycle as a HOLD→IDLE transfer is ignored; it is taken next cycle.
- GF arithmetic: carry-less multiply with reduction by PRIM_POLY, purely combinational; addition is XOR. All widths are SYM_W with no truncation anywhere.

Optional Feature:
Macro GF_EVAL_ZERO_FLAG_EN.
- Defined: adds output port zero_mask (NUM_PTS bits). Bit p is registered with result and equals (result_p==0), giving a root indicator for Chien search. Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package gf_pkg holds:
  - default SYM_W and PRIM_POLY constants;
  - state enum typedef (IDLE, ACCUM, HOLD);
  - a function for the primitive-polynomial reduction mask.
- One sub-module, gf_mul: parametrised (SYM_W, PRIM_POLY) combinational field multiplier, instantiated NUM_PTS times.

Test Plan:
1. Reset and idle: rst_n low mid-ACCUM, then release → busy=0, result_valid=0, result=0, coeff_ready=0; an offered coeff is ignored.
2. Roots of (x+1)(x+2), i.e. degree=2, coeffs 0x01,0x03,0x02, points {0x01,0x02,0x04,0x00} → result {0x00,0x00,0x1E,0x02}; zero_mask=4'b0011 if enabled.
3. Squaring: degree=2, coeffs 0x01,0x00,0x00, points x_0=0x80 → result_0=0x13; constant case degree=0, coeff 0xA5 → every result_p=0xA5.
4. Stalls and backpressure: random coeff_valid gaps, then result_ready held low for 10 cycles → results match the golden model, result is stable while held, and no extra coeff is accepted.
5. Full length: degree=MAX_DEG with random coefficients and points, back-to-back jobs with start asserted during HOLD → start is ignored while busy and results match the golden model.
